// File: rtl/switch_box_pkg.sv
// Shared constants and helpers for the parametrised routing switch box.
package switch_box_pkg;

    // Width of one per-output configuration field: 3 select bits + 1 mode bit.
    localparam int FIELD_W = 4;

    // Source select encodings (field bits [2:0]); 6 and 7 also yield zero.
    localparam logic [2:0] SRC_ZERO      = 3'd0;
    localparam logic [2:0] SRC_SIDE_BASE = 3'd1;
    localparam logic [2:0] SRC_PE        = 3'd5;

    // Side numbering used for track packing and own-side suppression.
    localparam int SIDE_N = 0;
    localparam int SIDE_E = 1;
    localparam int SIDE_S = 2;
    localparam int SIDE_W = 3;

    // Each track index needs 16 config bits (4 sides x 4 bits), two per 32-bit word.
    function automatic int num_words(input int tracks);
        return (tracks + 1) / 2;
    endfunction

endpackage

// File: rtl/sb_track_mux.sv
// One outgoing track: source mux with U-turn suppression, always-running
// pipeline register, and a per-output combinational/registered select.
module sb_track_mux
    import switch_box_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int SIDE  = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [4*WIDTH-1:0]   side_in,   // same track index on sides N,E,S,W
    input  logic [WIDTH-1:0]     pe_in,
    input  logic                 pipe_en,
    input  logic [FIELD_W-1:0]   field,
    output logic [WIDTH-1:0]     out_val
);

    logic [WIDTH-1:0] sel_val;
    logic [WIDTH-1:0] pipe_q;
    logic [WIDTH-1:0] pipe_d;

    // Source selection; selecting this output's own side routes zero.
    always_comb begin
        sel_val = '0;
        if (field[2:0] == SRC_PE) begin
            sel_val = pe_in;
        end
        for (int k = 0; k < 4; k++) begin
            if ((field[2:0] == (SRC_SIDE_BASE + 3'(k))) && (k != SIDE)) begin
                sel_val = side_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // Pipeline next state: capture whenever enabled, independent of the mode bit.
    always_comb begin
        pipe_d = pipe_en ? sel_val : pipe_q;
    end

    // Pipeline register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // Mode bit picks registered or combinational path.
    always_comb begin
        out_val = field[FIELD_W-1] ? pipe_q : sel_val;
    end

endmodule

// File: rtl/switch_box_param.sv
// Parametrised disjoint-topology switch box with double-buffered configuration.
// Writes land in a shadow image; a commit copies it to the active image that
// drives the per-output muxes, so live routes change atomically.
module switch_box_param
    import switch_box_pkg::*;
#(
    parameter int TRACKS = 4,
    parameter int WIDTH  = 1,
    // Defaults to the minimum needed; may be widened, addresses >= word count are ignored.
    parameter int ADDR_W = ($clog2(num_words(TRACKS)) > 1) ? $clog2(num_words(TRACKS)) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [4*TRACKS*WIDTH-1:0]   in_wires,
    input  logic [WIDTH-1:0]            pe_output,
    output logic [4*TRACKS*WIDTH-1:0]   out_wires,
    input  logic                        pipe_en,
    input  logic [ADDR_W-1:0]           config_addr,
    input  logic [31:0]                 config_data,
    input  logic                        config_en,
    input  logic                        config_commit,
    output logic [31:0]                 config_rd_data
);

    localparam int NUM_WORDS = num_words(TRACKS);
    localparam int CFG_BITS  = 16 * TRACKS;
    localparam int PAD_BITS  = 32 * NUM_WORDS;

    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [31:0]         rd_q, rd_d;
    logic [PAD_BITS-1:0] wr_pad;

    // Stored-bit mask of word w: the top half of the last word is absent for odd TRACKS.
    function automatic logic [31:0] word_mask(input int w);
        if (CFG_BITS - 32*w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return 32'h0000_FFFF;
    endfunction

    // Shadow write, post-write readback and commit of the post-write image.
    always_comb begin
        wr_pad = PAD_BITS'(shadow_q);
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (config_en && (config_addr == ADDR_W'(w))) begin
                wr_pad[w*32 +: 32] = config_data;
            end
        end
        shadow_d = wr_pad[CFG_BITS-1:0];
        rd_d = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (config_addr == ADDR_W'(w)) begin
                rd_d = wr_pad[w*32 +: 32] & word_mask(w);
            end
        end
        active_d = config_commit ? shadow_d : active_q;
    end

    // Configuration state and readback register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '0;
            active_q <= '0;
            rd_q     <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            rd_q     <= rd_d;
        end
    end

    assign config_rd_data = rd_q;

    // One mux per outgoing track; output s*TRACKS+t sees track t of every side.
    for (genvar gi = 0; gi < 4; gi++) begin : g_side
        for (genvar gj = 0; gj < TRACKS; gj++) begin : g_track
            localparam int O = gi*TRACKS + gj;
            logic [4*WIDTH-1:0] side_in;
            for (genvar gk = 0; gk < 4; gk++) begin : g_src
                assign side_in[gk*WIDTH +: WIDTH] = in_wires[((gk*TRACKS)+gj)*WIDTH +: WIDTH];
            end
            sb_track_mux #(
                .WIDTH (WIDTH),
                .SIDE  (gi)
            ) u_mux (
                .clk     (clk),
                .reset_n (reset_n),
                .side_in (side_in),
                .pe_in   (pe_output),
                .pipe_en (pipe_en),
                .field   (active_q[O*FIELD_W +: FIELD_W]),
                .out_val (out_wires[O*WIDTH +: WIDTH])
            );
        end
    end

endmodule

// File: tb/tb_switch_box_param.sv
// Bench for switch_box_param: directed vector table, corner sequences and
// random traffic against a word/field-level reference model.
module tb_switch_box_param;

    localparam int T    = 4;
    localparam int W    = 8;
    localparam int AW   = 2;
    localparam int NW   = 2;
    localparam int NOUT = 4*T;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n;
    logic [4*T*W-1:0]   in_wires;
    logic [W-1:0]       pe_output;
    logic [4*T*W-1:0]   out_wires;
    logic               pipe_en;
    logic [AW-1:0]      config_addr;
    logic [31:0]        config_data;
    logic               config_en;
    logic               config_commit;
    logic [31:0]        config_rd_data;

    switch_box_param #(.TRACKS(T), .WIDTH(W), .ADDR_W(AW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_wires       (in_wires),
        .pe_output      (pe_output),
        .out_wires      (out_wires),
        .pipe_en        (pipe_en),
        .config_addr    (config_addr),
        .config_data    (config_data),
        .config_en      (config_en),
        .config_commit  (config_commit),
        .config_rd_data (config_rd_data)
    );

    // Odd track count instance: exercises the unstored upper half of the last word.
    logic [23:0] in2;
    logic [1:0]  pe2;
    logic [23:0] out2;
    logic [0:0]  addr2;
    logic [31:0] data2;
    logic        en2, commit2;
    logic [31:0] rd2;

    switch_box_param #(.TRACKS(3), .WIDTH(2)) dut2 (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_wires       (in2),
        .pe_output      (pe2),
        .out_wires      (out2),
        .pipe_en        (pipe_en),
        .config_addr    (addr2),
        .config_data    (data2),
        .config_en      (en2),
        .config_commit  (commit2),
        .config_rd_data (rd2)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: config words and one held value per output.
    logic [31:0]  m_shadow [NW];
    logic [31:0]  m_active [NW];
    logic [W-1:0] m_pipe   [NOUT];
    logic [31:0]  m_rd;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  pe;
        int          oidx;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs [11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] dut_out(input int o);
        return out_wires[o*W +: W];
    endfunction

    function automatic logic [W-1:0] m_in(input int s, input int t);
        return in_wires[((s*T)+t)*W +: W];
    endfunction

    function automatic logic [3:0] m_field(input int o);
        logic [31:0] w;
        w = m_active[o/8] >> (4*(o%8));
        return w[3:0];
    endfunction

    function automatic logic [W-1:0] m_comb(input int o);
        logic [3:0] f;
        int src;
        f   = m_field(o);
        src = int'(f[2:0]);
        if (src >= 1 && src <= 4 && (src-1) != o/T) return m_in(src-1, o%T);
        if (src == 5) return pe_output;
        return '0;
    endfunction

    function automatic logic [W-1:0] m_out(input int o);
        logic [3:0] f;
        f = m_field(o);
        return f[3] ? m_pipe[o] : m_comb(o);
    endfunction

    function automatic logic [31:0] stored_mask(input int tracks, input int w);
        int bits;
        bits = 16*tracks - 32*w;
        if (bits >= 32) return 32'hFFFF_FFFF;
        if (bits <= 0) return 32'h0;
        return (32'h1 << bits) - 32'h1;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_shadow[w] = '0;
            m_active[w] = '0;
        end
        for (int o = 0; o < NOUT; o++) m_pipe[o] = '0;
        m_rd = '0;
    endtask

    // Effect of one rising edge, using the inputs present at that edge.
    task automatic model_edge();
        int a;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (pipe_en) begin
            for (int o = 0; o < NOUT; o++) m_pipe[o] = m_comb(o);
        end
        a = int'(config_addr);
        if (config_en && a < NW) m_shadow[a] = config_data & stored_mask(T, a);
        m_rd = (a < NW) ? m_shadow[a] : 32'h0;
        if (config_commit) begin
            for (int w = 0; w < NW; w++) m_active[w] = m_shadow[w];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        #1;
        for (int o = 0; o < NOUT; o++) begin
            chk($sformatf("%s_out%0d", tag, o), dut_out(o), m_out(o));
        end
        chk($sformatf("%s_rd", tag), config_rd_data, m_rd);
    endtask

    task automatic set_in(input int s, input int t, input logic [W-1:0] v);
        in_wires[((s*T)+t)*W +: W] = v;
    endtask

    task automatic set_pattern();
        for (int s = 0; s < 4; s++)
            for (int t = 0; t < T; t++)
                set_in(s, t, 8'(16*(s+1) + t));
    endtask

    task automatic cfg_write(input int addr, input logic [31:0] data, input logic commit);
        config_en     = 1'b1;
        config_addr   = AW'(addr);
        config_data   = data;
        config_commit = commit;
        tick();
        config_en     = 1'b0;
        config_commit = 1'b0;
        $display("cfg write addr=%0d data=%08h commit=%b", addr, data, commit);
    endtask

    initial begin
        logic [W-1:0] prev, v, held;

        vecs[0]  = '{32'h0000_0003, 32'h0, 8'h77, 0,  8'h30};
        vecs[1]  = '{32'h0000_0003, 32'h0, 8'h77, 1,  8'h00};
        vecs[2]  = '{32'h0020_0000, 32'h0, 8'h77, 5,  8'h00};
        vecs[3]  = '{32'h0050_0000, 32'h0, 8'h3C, 5,  8'h3C};
        vecs[4]  = '{32'h0010_0000, 32'h0, 8'h77, 5,  8'h11};
        vecs[5]  = '{32'h0000_0006, 32'h0, 8'h77, 0,  8'h00};
        vecs[6]  = '{32'h0000_0007, 32'h0, 8'h77, 0,  8'h00};
        vecs[7]  = '{32'h0, 32'h0000_0004, 8'h77, 8,  8'h40};
        vecs[8]  = '{32'h0, 32'h0000_3000, 8'h77, 11, 8'h00};
        vecs[9]  = '{32'h0, 32'h2000_0000, 8'h77, 15, 8'h23};
        vecs[10] = '{32'h4000_0000, 32'h0, 8'h77, 7,  8'h43};

        model_reset();
        reset_n = 1'b1;
        in_wires = '0; pe_output = '0; pipe_en = 1'b0;
        config_addr = '0; config_data = '0; config_en = 1'b0; config_commit = 1'b0;
        in2 = '0; pe2 = '0; addr2 = '0; data2 = '0; en2 = 1'b0; commit2 = 1'b0;
        #2 reset_n = 1'b0;

        // Reset held with activity on every input: everything stays zero.
        for (int i = 0; i < 3; i++) begin
            in_wires = {$urandom, $urandom, $urandom, $urandom};
            pe_output = 8'($urandom);
            pipe_en = 1'b1; config_en = 1'b1; config_commit = 1'b1;
            config_data = $urandom; config_addr = AW'($urandom_range(0, 1));
            tick();
            chk($sformatf("rst_out%0d", i), out_wires, '0);
            chk($sformatf("rst_rd%0d", i), config_rd_data, 32'h0);
            $display("reset cycle %0d", i);
        end
        config_en = 1'b0; config_commit = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_wires = {$urandom, $urandom, $urandom, $urandom};
            pe_output = 8'($urandom);
            tick();
            chk($sformatf("post_rst_out%0d", i), out_wires, '0);
            $display("post-reset cycle %0d", i);
        end

        // Basic routing: invisible before commit, zero latency after.
        in_wires = '0;
        set_in(2, 0, 8'hA5);
        cfg_write(0, 32'h0000_0003, 1'b0);
        #1 chk("n0_before_commit", dut_out(0), 8'h00);
        chk("rd_word0", config_rd_data, 32'h0000_0003);
        config_commit = 1'b1;
        tick();
        config_commit = 1'b0;
        #1 chk("n0_after_commit", dut_out(0), 8'hA5);
        set_in(2, 0, 8'h5A);
        #1 chk("n0_zero_latency", dut_out(0), 8'h5A);
        check_model("basic");

        // Table of routing vectors: word0 write, then word1 write with commit.
        for (int i = 0; i < 11; i++) begin
            set_pattern();
            pe_output = vecs[i].pe;
            cfg_write(0, vecs[i].w0, 1'b0);
            cfg_write(1, vecs[i].w1, 1'b1);
            #1 chk($sformatf("vec%0d", i), dut_out(vecs[i].oidx), vecs[i].exp);
            $display("vec%0d o%0d out=%02h", i, vecs[i].oidx, dut_out(vecs[i].oidx));
            check_model($sformatf("vec%0d", i));
        end

        // Registered mode: N0 from W0 with one-cycle lag, holds while pipe_en=0.
        pipe_en = 1'b1;
        set_pattern();
        cfg_write(0, 32'h0000_000C, 1'b0);
        cfg_write(1, 32'h0, 1'b1);
        check_model("reg_commit");
        set_in(3, 0, 8'h11);
        tick();
        #1 chk("reg_first", dut_out(0), 8'h11);
        prev = 8'h11;
        for (int k = 0; k < 4; k++) begin
            v = ~prev ^ 8'(k);
            set_in(3, 0, v);
            #1 chk($sformatf("reg_lag%0d", k), dut_out(0), prev);
            tick();
            #1 chk($sformatf("reg_new%0d", k), dut_out(0), v);
            $display("reg cycle %0d in=%02h out=%02h", k, v, dut_out(0));
            prev = v;
        end
        held = prev;
        pipe_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_in(3, 0, 8'($urandom) ^ held ^ 8'h01);
            tick();
            #1 chk($sformatf("reg_hold%0d", k), dut_out(0), held);
        end
        pipe_en = 1'b1;
        check_model("reg_end");

        // Odd track count: upper half of the last word is not stored.
        en2 = 1'b1; addr2 = 1'b1; data2 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk("odd_rd_w1", rd2, 32'h0000_FFFF);
        addr2 = 1'b0; data2 = 32'h1234_5678;
        @(posedge clk); #1;
        chk("odd_rd_w0", rd2, 32'h1234_5678);
        en2 = 1'b0; addr2 = 1'b1;
        @(posedge clk); #1;
        chk("odd_rd_w1_again", rd2, 32'h0000_FFFF);
        $display("odd-track readback done");

        // Out-of-range write is ignored and reads back zero.
        cfg_write(3, 32'hFFFF_FFFF, 1'b0);
        #1 chk("oor_rd", config_rd_data, 32'h0);
        check_model("oor");
        cfg_write(2, 32'hDEAD_BEEF, 1'b1);
        check_model("oor2");
        config_addr = 2'd0; tick(); check_model("oor_rd0");
        config_addr = 2'd1; tick(); check_model("oor_rd1");

        // Reset during a pending commit: the commit is lost.
        set_pattern();
        cfg_write(0, 32'h0000_0002, 1'b0);
        config_commit = 1'b1;
        #1 reset_n = 1'b0;
        model_reset();
        #1 chk("rstc_out_async", out_wires, '0);
        chk("rstc_rd_async", config_rd_data, 32'h0);
        tick();
        reset_n = 1'b1;
        config_commit = 1'b0;
        config_addr = 2'd0;
        tick();
        #1 chk("rstc_n0", dut_out(0), 8'h00);
        chk("rstc_rd", config_rd_data, 32'h0);
        check_model("rstc");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_wires      = {$urandom, $urandom, $urandom, $urandom};
            pe_output     = 8'($urandom);
            pipe_en       = ($urandom_range(0, 3) != 0);
            config_en     = ($urandom_range(0, 2) == 0);
            config_commit = ($urandom_range(0, 6) == 0);
            config_addr   = AW'($urandom_range(0, 3));
            config_data   = $urandom;
            check_model($sformatf("rnd%0d", i));
            tick();
            $display("rnd %0d en=%b addr=%0d commit=%b pipe=%b", i, config_en, config_addr,
                     config_commit, pipe_en);
        end
        config_en = 1'b0; config_commit = 1'b0;
        check_model("rnd_end");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
